// File: rtl/music_pkg.sv
// Shared definitions for the song sequencer: note codes, FSM states,
// song ROM word field offsets and the note -> one-hot LED mapping.
// No ports; imported by song_sequencer.
package music_pkg;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  // ROM word layout: {duration, octave[1:0], note[3:0]}
  localparam int NOTE_LSB = 0;
  localparam int OCT_LSB  = 4;
  localparam int DUR_LSB  = 6;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  // Notes 1..7 light bit n-1; rest, end marker and unused codes light nothing.
  function automatic logic [6:0] note_led(input logic [3:0] note);
    logic [6:0] led;
    led = '0;
    if (note >= 4'd1 && note <= 4'd7) led = 7'd1 << (note - 4'd1);
    return led;
  endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Beat timebase: counts enabled cycles 0..TICK_DIV-1 and pulses tick for one
// cycle on the terminal count. Ports: clk, reset (sync, active-high),
// clear (restart count from 0), enable (count this cycle), tick (beat pulse).
module beat_tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Auto-play sequencer: walks an external song ROM and drives note, octave and
// LED for each entry's beat count, with loop, pause, inter-note gap and
// next/prev song buttons. Ports: clk, reset, btn_next, btn_prev, play_en,
// loop_en, rom_addr/rom_data (1-cycle ROM), note_to_play, octave_auto,
// led_out, song_num, done.
module song_sequencer
  import music_pkg::*;
#(
  parameter int NUM_SONGS = 3,
  parameter int SONG_LEN  = 56,
  parameter int TICK_DIV  = 10_000_000,
  parameter int DUR_W     = 4,
  parameter int GAP_CYC   = 0,
  localparam int SONG_W   = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int POS_W    = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_next,
  input  logic                    btn_prev,
  input  logic                    play_en,
  input  logic                    loop_en,
  output logic [SONG_W+POS_W-1:0] rom_addr,
  input  logic [6+DUR_W-1:0]      rom_data,
  output logic [3:0]              note_to_play,
  output logic [1:0]              octave_auto,
  output logic [6:0]              led_out,
  output logic [SONG_W-1:0]       song_num,
  output logic                    done
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SONG_LEN - 1);
  localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

  state_t             state, state_nxt;
  logic [POS_W-1:0]   pos;
  logic [DUR_W-1:0]   beats_left;
  logic [GAP_W-1:0]   gap_cnt;
  logic               btn_next_q, btn_prev_q;
  logic               tick;

  logic               load_note, silence, beat_dec, gap_inc;
  logic               pos_inc, pos_zero, entry_end;

  logic [3:0]         rom_note;
  logic [1:0]         rom_oct;
  logic [DUR_W-1:0]   rom_dur;

  assign rom_note = rom_data[NOTE_LSB +: 4];
  assign rom_oct  = rom_data[OCT_LSB +: 2];
  assign rom_dur  = rom_data[DUR_LSB +: DUR_W];

  // A rising edge on exactly one button changes song; both at once cancel.
  logic rise_next, rise_prev, song_chg;
  assign rise_next = btn_next && !btn_next_q;
  assign rise_prev = btn_prev && !btn_prev_q;
  assign song_chg  = rise_next ^ rise_prev;

  assign rom_addr = {song_num, pos};
  assign done     = (state == ST_DONE);

  beat_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state != ST_PLAY) || song_chg),
    .enable ((state == ST_PLAY) && play_en),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_note = 1'b0;
    silence   = 1'b0;
    beat_dec  = 1'b0;
    gap_inc   = 1'b0;
    pos_inc   = 1'b0;
    pos_zero  = 1'b0;
    entry_end = 1'b0;
    unique case (state)
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rom_note == NOTE_END) begin
          if (loop_en) begin
            pos_zero  = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            silence   = 1'b1;
            state_nxt = ST_DONE;
          end
        end else begin
          load_note = 1'b1;
          state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // tick only fires while play_en is high, so pause freezes here.
        if (tick) begin
          if (beats_left == DUR_W'(1)) begin
            silence = 1'b1;
            if (GAP_CYC > 0) state_nxt = ST_GAP;
            else             entry_end = 1'b1;
          end else begin
            beat_dec = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (play_en) begin
          if (gap_cnt == GAP_LAST) entry_end = 1'b1;
          else                     gap_inc   = 1'b1;
        end
      end
      default: ;
    endcase
    // The last ROM slot of a song behaves like an end marker.
    if (entry_end) begin
      if (pos == POS_LAST) begin
        if (loop_en) begin
          pos_zero  = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_DONE;
        end
      end else begin
        pos_inc   = 1'b1;
        state_nxt = ST_FETCH;
      end
    end
    if (song_chg) state_nxt = ST_FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_next_q   <= 1'b0;
      btn_prev_q   <= 1'b0;
      song_num     <= '0;
      pos          <= '0;
      beats_left   <= '0;
      gap_cnt      <= '0;
      note_to_play <= NOTE_REST;
      octave_auto  <= '0;
      led_out      <= '0;
    end else begin
      btn_next_q <= btn_next;
      btn_prev_q <= btn_prev;
      if (song_chg) begin
        if (rise_next) song_num <= (song_num == SONG_LAST) ? '0 : song_num + SONG_W'(1);
        else           song_num <= (song_num == '0) ? SONG_LAST : song_num - SONG_W'(1);
        pos          <= '0;
        beats_left   <= '0;
        gap_cnt      <= '0;
        note_to_play <= NOTE_REST;
        octave_auto  <= '0;
        led_out      <= '0;
      end else begin
        if (load_note) begin
          note_to_play <= rom_note;
          octave_auto  <= rom_oct;
          led_out      <= note_led(rom_note);
          beats_left   <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
          gap_cnt      <= '0;
        end
        if (silence) begin
          note_to_play <= NOTE_REST;
          octave_auto  <= '0;
          led_out      <= '0;
        end
        if (beat_dec) beats_left <= beats_left - DUR_W'(1);
        if (gap_inc)  gap_cnt    <= gap_cnt + GAP_W'(1);
        if (pos_zero)     pos <= '0;
        else if (pos_inc) pos <= pos + POS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed song/loop/button scenarios followed by
// randomized play, pause, button and reset traffic, every cycle compared with
// a timeline model that expands each ROM entry into its expected output steps.
module tb_song_sequencer;

  localparam int NUM_SONGS = 3;
  localparam int SONG_LEN  = 4;
  localparam int TICK_DIV  = 4;
  localparam int DUR_W     = 4;
  localparam int GAP_CYC   = 3;

  logic       clk, reset, btn_next, btn_prev, play_en, loop_en;
  logic [3:0] rom_addr;
  logic [9:0] rom_data;
  logic [3:0] note_to_play;
  logic [1:0] octave_auto;
  logic [6:0] led_out;
  logic [1:0] song_num;
  logic       done;

  song_sequencer #(
    .NUM_SONGS(NUM_SONGS), .SONG_LEN(SONG_LEN), .TICK_DIV(TICK_DIV),
    .DUR_W(DUR_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .play_en(play_en), .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_to_play(note_to_play), .octave_auto(octave_auto), .led_out(led_out),
    .song_num(song_num), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song library: registered ROM, data one cycle after address.
  logic [9:0] rom_mem [16];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each ROM entry expands to: two silent fetch cycles, then dur*TICK_DIV
  // cycles of the note, then GAP_CYC silent cycles. Note and gap cycles only
  // elapse while play_en is high; fetch cycles always elapse.
  typedef struct packed {
    logic       timed;
    logic [3:0] note;
    logic [1:0] oct;
    logic [6:0] led;
  } step_t;

  localparam step_t ZS = '0;

  step_t q[$];
  step_t cur;
  int    gen_pos;
  bit    m_end, m_done;
  int    m_song;
  logic  pn, pp;

  function automatic logic [6:0] exp_led(input logic [3:0] n);
    logic [6:0] v;
    v = '0;
    if (n >= 4'd1 && n <= 4'd7) v[n-1] = 1'b1;
    return v;
  endfunction

  task automatic gen_entry();
    logic [9:0] e;
    int d;
    step_t s;
    e = rom_mem[m_song * SONG_LEN + gen_pos];
    q.push_back(ZS);
    q.push_back(ZS);
    if (e[3:0] == 4'hF) begin
      if (loop_en) gen_pos = 0;
      else         m_end = 1;
      return;
    end
    d = (e[9:6] == 4'd0) ? 1 : int'(e[9:6]);
    s = '{timed: 1'b1, note: e[3:0], oct: e[5:4], led: exp_led(e[3:0])};
    for (int i = 0; i < d * TICK_DIV; i++) q.push_back(s);
    s = '{timed: 1'b1, note: 4'd0, oct: 2'd0, led: 7'd0};
    for (int i = 0; i < GAP_CYC; i++) q.push_back(s);
    if (gen_pos == SONG_LEN - 1) begin
      if (loop_en) gen_pos = 0;
      else         m_end = 1;
    end else begin
      gen_pos++;
    end
  endtask

  task automatic advance();
    if (q.size() == 0 && !m_end) gen_entry();
    if (q.size() > 0) begin
      cur = q.pop_front();
      m_done = 0;
    end else begin
      cur = ZS;
      m_done = 1;
    end
  endtask

  task automatic restart();
    q.delete();
    gen_pos = 0;
    m_end = 0;
    m_done = 0;
    advance();
  endtask

  always @(posedge clk) begin
    logic rn, rp;
    if (reset) begin
      pn = 1'b0;
      pp = 1'b0;
      m_song = 0;
      restart();
    end else begin
      rn = btn_next && !pn;
      rp = btn_prev && !pp;
      pn = btn_next;
      pp = btn_prev;
      if (rn != rp) begin
        m_song = rn ? (m_song + 1) % NUM_SONGS : (m_song + NUM_SONGS - 1) % NUM_SONGS;
        restart();
      end else if (!m_done && !(cur.timed && !play_en)) begin
        advance();
      end
    end
  end

  bit mon_en = 0;
  bit cnt_en = 0;
  int cnt_n1, cnt_n2, cnt_done;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("note",   32'(note_to_play), 32'(cur.note));
      chk("octave", 32'(octave_auto),  32'(cur.oct));
      chk("led",    32'(led_out),      32'(cur.led));
      chk("done",   32'(done),         32'(m_done));
      chk("song",   32'(song_num),     32'(m_song));
    end
    if (cnt_en) begin
      if (note_to_play == 4'd1) cnt_n1++;
      if (note_to_play == 4'd2) cnt_n2++;
      if (done) cnt_done++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] mk(input int n, input int o, input int d);
    return {4'(d), 2'(o), 4'(n)};
  endfunction

  task automatic rand_roms();
    int n;
    for (int a = 0; a < 16; a++) begin
      n = $urandom_range(0, 9);
      if (n > 7) n = 15;
      rom_mem[a] = mk(n, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    loop_en = 1'($urandom_range(0, 1));
    rand_roms();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int hold_n, hold_p, pause_left, r;
    reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; play_en = 1'b1; loop_en = 1'b0;
    rand_roms();
    rom_mem[0] = mk(1, 1, 2);
    rom_mem[1] = mk(2, 0, 0);
    rom_mem[2] = mk(15, 0, 0);
    rom_mem[3] = mk(3, 2, 1);
    step();
    step();
    mon_en = 1;
    chk("rst_note", 32'(note_to_play), 32'd0);
    chk("rst_led",  32'(led_out),      32'd0);
    chk("rst_song", 32'(song_num),     32'd0);
    chk("rst_done", 32'(done),         32'd0);

    // Song 0 once through: n1 for 2 beats, n2 for 1 beat, then DONE.
    reset = 1'b0;
    cnt_n1 = 0; cnt_n2 = 0; cnt_done = 0; cnt_en = 1;
    repeat (40) step();
    cnt_en = 0;
    chk("n1_cycles", 32'(cnt_n1), 32'd8);
    chk("n2_cycles", 32'(cnt_n2), 32'd4);
    chk("end_done",  32'(done),   32'd1);
    chk("end_note",  32'(note_to_play), 32'd0);

    // Same song looping: never done, first note heard more than once.
    reset = 1'b1; loop_en = 1'b1;
    step(); step();
    reset = 1'b0;
    cnt_n1 = 0; cnt_n2 = 0; cnt_done = 0; cnt_en = 1;
    repeat (80) step();
    cnt_en = 0;
    chk("loop_no_done", 32'(cnt_done), 32'd0);
    chk("loop_repeats", 32'(cnt_n1 > 8), 32'd1);

    // Button wraps, simultaneous press, held button.
    btn_prev = 1'b1; step(); btn_prev = 1'b0;
    chk("prev_wrap", 32'(song_num), 32'd2);
    step();
    btn_next = 1'b1; btn_prev = 1'b1; step();
    chk("both_ignored", 32'(song_num), 32'd2);
    btn_next = 1'b0; btn_prev = 1'b0; step();
    btn_next = 1'b1; step();
    chk("next_wrap", 32'(song_num), 32'd0);
    step(); step();
    chk("held_once", 32'(song_num), 32'd0);
    btn_next = 1'b0;
    repeat (6) step();

    // Randomized traffic.
    hold_n = 0; hold_p = 0; pause_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) < 4) begin
        do_reset();
        hold_n = 0; hold_p = 0;
      end
      if (hold_n == 0 && hold_p == 0) begin
        r = $urandom_range(0, 99);
        if (r < 2)       hold_n = $urandom_range(1, 4);
        else if (r < 4)  hold_p = $urandom_range(1, 4);
        else if (r == 4) begin hold_n = 2; hold_p = 2; end
      end
      btn_next = (hold_n > 0);
      btn_prev = (hold_p > 0);
      if (hold_n > 0) hold_n--;
      if (hold_p > 0) hold_p--;
      if (pause_left > 0) begin
        play_en = 1'b0;
        pause_left--;
      end else begin
        play_en = 1'b1;
        if ($urandom_range(0, 99) < 3) pause_left = $urandom_range(1, 12);
      end
      step();
    end

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
